exec_cc_ctrl: RTL

Execute-stage control for the Y86-64 datapath. It sits on the driving side of the 64-bit ALU. It decodes icode/ifun into the ALU 2-bit control and the two ALU operands, then takes the ALU result and overflow back. From those it maintains the architectural condition-code register (ZF/SF/OF) and evaluates the jXX/cmovXX condition. The CC register is the block's state; the operand and control path is combinational.

---
 rtl/exec_cc_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/exec_cc_ctrl.sv
// Y86-64 execute-stage control: ALU operand/control decode, ZF/SF/OF condition-code
// register, and jXX/cmovXX condition evaluation.
module exec_cc_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        exc_block,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [63:0] val_a,
   input  logic [63:0] val_b,
   input  logic [63:0] val_c,
   output logic [1:0]  alu_ctrl,
   output logic [63:0] alu_a,
   output logic [63:0] alu_b,
   input  logic [63:0] alu_out,
   input  logic        alu_ovf,
   output logic [63:0] val_e,
   output logic        zf,
   output logic        sf,
   output logic        of,
   output logic        cnd,
   output logic        bad_cond
);

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   localparam logic [63:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [63:0] STACK_INC = 64'h0000_0000_0000_0008;

   logic set_cc;

   assign set_cc = valid & (icode == I_OPQ) & ~exc_block;
   assign val_e  = alu_out;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      alu_ctrl = 2'b00;
      alu_a    = '0;
      alu_b    = '0;
      if (icode == I_OPQ)
         alu_ctrl = ifun[1:0];
      case (icode)
         I_RRMOVQ, I_OPQ:           alu_b = val_a;
         I_IRMOVQ, I_RMMOVQ,
         I_MRMOVQ:                  alu_b = val_c;
         I_CALL, I_PUSHQ:           alu_b = STACK_DEC;
         I_RET, I_POPQ:             alu_b = STACK_INC;
         default:                   alu_b = '0;
      endcase
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ,
         I_CALL, I_RET, I_PUSHQ,
         I_POPQ:                    alu_a = val_b;
         default:                   alu_a = '0;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flags update together at the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         zf <= 1'b1;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (set_cc) begin
         zf <= (alu_out == 64'd0);
         sf <= alu_out[63];
         of <= alu_ovf;
      end
   end

   // Conditions read the registered flags, i.e. the last completed OPq.
   always_comb begin
      cnd      = 1'b0;
      bad_cond = 1'b0;
      if (valid && (icode == I_RRMOVQ || icode == I_JXX)) begin
         case (ifun)
            4'h0:    cnd = 1'b1;
            4'h1:    cnd = (sf ^ of) | zf;
            4'h2:    cnd = sf ^ of;
            4'h3:    cnd = zf;
            4'h4:    cnd = ~zf;
            4'h5:    cnd = ~(sf ^ of);
            4'h6:    cnd = ~(sf ^ of) & ~zf;
            default: bad_cond = 1'b1;
         endcase
      end
   end

endmodule
